bp_be_fma_wb_tracker: RTL and testbench
=======================================

# bp_be_fma_wb_tracker

Writeback-tagging stage directly downstream of the FMA/IMUL calculator pipe. The pipe returns results and flags with fixed latencies but carries no destination register or kill state, so this block captures the destination at issue, delays it in step with the pipe, and pairs it with each returning result. It produces FP and integer writeback packets and per-register busy masks for RAW stall logic. It also owns the sticky accrued-fflags register and suppresses writeback for flushed operations.

## Interface
- bp_params_p, e_bp_default_cfg, processor configuration
- fma_latency_p, 5, issue-to-FMA-valid distance plus one; must be ≥3
- imul_latency_p, 4, issue-to-IMUL-valid distance plus one; must be ≥2
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- issue_v_i  in  1  op dispatched to calculator pipe this cycle
- issue_fma_i  in  1  1 = FMA op, 0 = IMUL op
- issue_rd_i  in  5  destination register
- flush_i  in  1  kill every in-flight op, including one issuing this cycle
- fma_v_i  in  1  FMA result valid from pipe
- fma_data_i  in  $bits(bp_be_fp_reg_s)  FMA result
- fma_fflags_i  in  5  FMA exception flags (rv64_fflags_s)
- imul_v_i  in  1  IMUL result valid
- imul_data_i  in  dpath_width_gp  IMUL result
- fflags_clear_i  in  1  CSR write clears accrued flags
- fp_wb_v_o  out  1  FP writeback valid
- fp_wb_rd_o  out  5  FP writeback register
- fp_wb_data_o  out  $bits(bp_be_fp_reg_s)  FP writeback data
- int_wb_v_o  out  1  integer writeback valid
- int_wb_rd_o  out  5  integer writeback register
- int_wb_data_o  out  dpath_width_gp  integer writeback data
- fflags_acc_o  out  5  sticky accrued flags
- fp_busy_o  out  32  FP registers with a live pending write
- int_busy_o  out  32  integer registers with a live pending write; bit 0 always 0
- err_o  out  1  sticky: result arrived with no matching tag

## Operation
- Two tag shift registers: FMA depth fma_latency_p-1, IMUL depth imul_latency_p-1. Entry fields: v, kill, rd.
- Issue: entry {1, flush_i, issue_rd_i} enters the selected register. Every other stage shifts by one each cycle.
- flush_i sets kill on every valid entry in both registers in the same cycle.
- Head entry pairs with fma_v_i or imul_v_i. Writeback valid = valid_in & head.v & ~head.kill. The rd field comes from the head; data passes through combinationally.
- A killed head consumes its result silently. No writeback and no flag accrual.
- err_o sets when a result valid arrives with head.v=0. It also sets when head.v=1 and the result valid is absent. It clears only on reset.
- IMUL to rd 0: the tag still tracks, but int_wb_v_o is suppressed and int_busy_o[0] is never set.
- Busy: fp_busy_o[r] is the OR over live (v & ~kill) FMA entries with rd=r, including the issuing entry this cycle. int_busy_o is the same over IMUL entries.
- Flags: acc <= fflags_clear_i ? new : acc | new. Here new = fma_fflags_i when fp_wb_v_o, else 0.

## Timing
- Issue at cycle t: fma_v_i at t+fma_latency_p-1; imul_v_i at t+imul_latency_p-1.
- Writeback outputs are combinational in the arrival cycle. The block adds zero latency.
- fflags_acc_o reflects accrued flags one cycle after the writeback.
- Busy bit rises combinationally in the issue cycle. It falls the cycle after writeback.
- One issue per cycle maximum. Back-to-back issues to the same rd keep the bit set until the last one retires.
- Simultaneous flush and result arrival: the arriving head is killed and writeback is suppressed.
- Reset, including mid-operation: all entries invalid, all outputs 0, fflags_acc_o=0, err_o=0. Results already in the pipe after reset are ignored while err_o is masked for fma_latency_p-1 cycles.

## Structure
- bp_be_pkg: typedef bp_be_wb_tag_s {v, kill, rd[4:0]}.
- Sub-module bp_be_wb_tag_shift is a parameterised depth shift register with a flush-kill input and a combinational live-rd mask output. It is instantiated twice.
- The flag accumulator, err logic and writeback muxing live in the top module.

## Test plan
- FMA issue rd=7 at cycle 10; fma_v_i at 14 with flags 5'b00001 -> fp_wb_v_o=1 and fp_wb_rd_o=7 at 14; fp_busy_o[7] high cycles 10-14; fflags_acc_o=1 at 15.
- IMUL rd=3 at 10 and FMA rd=3 at 11 -> int_wb at 13 and fp_wb at 15; the int and fp busy bits clear independently.
- FMA rd=9 at 10, flush_i at 12 -> fp_busy_o[9] drops at 12; no wb at 14; err_o stays 0.
- FMA rd=4 at cycles 10 and 11 -> fp_busy_o[4] high 10-15; two writebacks at 14 and 15.
- fflags_clear_i at 20 with wb flags 5'b10000 -> fflags_acc_o=5'b10000 at 21.
- fma_v_i with no prior issue -> err_o=1 next cycle and remains 1 until reset.

Source files
------------

// File: rtl/bp_be_fma_wb_tracker_pkg.sv
// Shared types for the FMA/IMUL writeback tracker: FP register format, fflags layout,
// the writeback tag carried alongside the calculator pipe, and configuration helpers.
package bp_be_fma_wb_tracker_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_unicore_cfg
    } bp_params_e;

    localparam int unsigned dpath_width_gp    = 64;
    localparam int unsigned reg_addr_width_gp = 5;
    localparam int unsigned num_regs_gp       = 32;

    // Recoded FP register: one extra bit over the datapath plus a single-precision marker
    typedef struct packed {
        logic                      sp_not_dp;
        logic [dpath_width_gp:0]   rec;
    } bp_be_fp_reg_s;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } rv64_fflags_s;

    typedef struct packed {
        logic                         v;
        logic                         kill;
        logic [reg_addr_width_gp-1:0] rd;
    } bp_be_wb_tag_s;

    // Integer datapath width implied by a processor configuration
    function automatic int unsigned cfg_dpath_width(bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return 64;
            e_bp_unicore_cfg: return 64;
            default:          return 0;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_fma_wb_tracker_if.sv
// Issue, pipe-return and writeback signals between the calculator pipe and the tracker.
interface bp_be_fma_wb_tracker_if;

    logic                                              issue_v_i;
    logic                                              issue_fma_i;
    logic [bp_be_fma_wb_tracker_pkg::reg_addr_width_gp-1:0] issue_rd_i;
    logic                                              flush_i;
    logic                                              fma_v_i;
    bp_be_fma_wb_tracker_pkg::bp_be_fp_reg_s           fma_data_i;
    bp_be_fma_wb_tracker_pkg::rv64_fflags_s            fma_fflags_i;
    logic                                              imul_v_i;
    logic [bp_be_fma_wb_tracker_pkg::dpath_width_gp-1:0]    imul_data_i;
    logic                                              fflags_clear_i;

    logic                                              fp_wb_v_o;
    logic [bp_be_fma_wb_tracker_pkg::reg_addr_width_gp-1:0] fp_wb_rd_o;
    bp_be_fma_wb_tracker_pkg::bp_be_fp_reg_s           fp_wb_data_o;
    logic                                              int_wb_v_o;
    logic [bp_be_fma_wb_tracker_pkg::reg_addr_width_gp-1:0] int_wb_rd_o;
    logic [bp_be_fma_wb_tracker_pkg::dpath_width_gp-1:0]    int_wb_data_o;
    bp_be_fma_wb_tracker_pkg::rv64_fflags_s            fflags_acc_o;
    logic [bp_be_fma_wb_tracker_pkg::num_regs_gp-1:0]       fp_busy_o;
    logic [bp_be_fma_wb_tracker_pkg::num_regs_gp-1:0]       int_busy_o;
    logic                                              err_o;

    modport master (
        output issue_v_i, issue_fma_i, issue_rd_i, flush_i, fma_v_i, fma_data_i, fma_fflags_i,
               imul_v_i, imul_data_i, fflags_clear_i,
        input  fp_wb_v_o, fp_wb_rd_o, fp_wb_data_o, int_wb_v_o, int_wb_rd_o, int_wb_data_o,
               fflags_acc_o, fp_busy_o, int_busy_o, err_o
    );

    modport slave (
        input  issue_v_i, issue_fma_i, issue_rd_i, flush_i, fma_v_i, fma_data_i, fma_fflags_i,
               imul_v_i, imul_data_i, fflags_clear_i,
        output fp_wb_v_o, fp_wb_rd_o, fp_wb_data_o, int_wb_v_o, int_wb_rd_o, int_wb_data_o,
               fflags_acc_o, fp_busy_o, int_busy_o, err_o
    );

endinterface

// File: rtl/bp_be_wb_tag_shift.sv
// Destination-tag delay line that walks in step with one calculator pipe. The head entry
// lines up with the pipe's result valid; a flush marks every in-flight tag as killed.
module bp_be_wb_tag_shift
    import bp_be_fma_wb_tracker_pkg::*;
#(
    parameter int unsigned depth_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_v_i,
    input  logic [reg_addr_width_gp-1:0] push_rd_i,
    input  logic                         flush_i,
    output bp_be_wb_tag_s                head_o,
    output logic [num_regs_gp-1:0]       live_o
);

    bp_be_wb_tag_s tag_q [depth_p];
    bp_be_wb_tag_s tag_d [depth_p];

    // Next state: new tag enters stage 0, the rest shift, flush kills everything in flight
    always_comb begin
        tag_d[0].v    = push_v_i;
        tag_d[0].kill = push_v_i & flush_i;
        tag_d[0].rd   = push_v_i ? push_rd_i : '0;
        for (int k = 1; k < int'(depth_p); k++) begin
            tag_d[k]      = tag_q[k-1];
            tag_d[k].kill = tag_q[k-1].kill | (tag_q[k-1].v & flush_i);
        end
    end

    // Head seen by the result; a same-cycle flush kills it before it can write back
    always_comb begin
        head_o      = tag_q[depth_p-1];
        head_o.kill = tag_q[depth_p-1].kill | flush_i;
    end

    // Registers with a live pending write, including the tag entering this cycle
    always_comb begin
        live_o = '0;
        if (push_v_i && !flush_i) begin
            live_o[push_rd_i] = 1'b1;
        end
        for (int k = 0; k < int'(depth_p); k++) begin
            if (tag_q[k].v && !tag_q[k].kill && !flush_i) begin
                live_o[tag_q[k].rd] = 1'b1;
            end
        end
    end

    // Tag storage
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_q <= '{default: '0};
        end else begin
            tag_q <= tag_d;
        end
    end

endmodule

// File: rtl/bp_be_fma_wb_tracker.sv
// Writeback tagging for the FMA/IMUL calculator pipe: pairs returning results with the
// destination captured at issue, drops flushed ops, tracks busy registers, accrues fflags
// and flags any result/tag misalignment.
module bp_be_fma_wb_tracker
    import bp_be_fma_wb_tracker_pkg::*;
#(
    parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
    parameter int unsigned fma_latency_p  = 5,
    parameter int unsigned imul_latency_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_be_fma_wb_tracker_if.slave  trk_io
);

    localparam int unsigned fma_depth_lp  = fma_latency_p - 1;
    localparam int unsigned imul_depth_lp = imul_latency_p - 1;
    localparam int unsigned mask_width_lp = $clog2(fma_latency_p);
    localparam logic [mask_width_lp-1:0] mask_init_lp = mask_width_lp'(fma_depth_lp);

    if (fma_latency_p < 3) begin : g_bad_fma_latency
        $error("fma_latency_p must be at least 3");
    end
    if (imul_latency_p < 2) begin : g_bad_imul_latency
        $error("imul_latency_p must be at least 2");
    end
    if (cfg_dpath_width(bp_params_p) != dpath_width_gp) begin : g_bad_cfg
        $error("configuration datapath width does not match dpath_width_gp");
    end

    bp_be_wb_tag_s            fma_head, imul_head;
    logic [num_regs_gp-1:0]   fma_live, imul_live;
    logic                     fp_wb_v, int_wb_v, tag_err;
    logic [4:0]               new_flags, fflags_d, fflags_q;
    logic                     err_d, err_q;
    logic [mask_width_lp-1:0] mask_d, mask_q;

    bp_be_wb_tag_shift #(
        .depth_p (fma_depth_lp)
    ) fma_tags (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_v_i  (trk_io.issue_v_i & trk_io.issue_fma_i),
        .push_rd_i (trk_io.issue_rd_i),
        .flush_i   (trk_io.flush_i),
        .head_o    (fma_head),
        .live_o    (fma_live)
    );

    bp_be_wb_tag_shift #(
        .depth_p (imul_depth_lp)
    ) imul_tags (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_v_i  (trk_io.issue_v_i & ~trk_io.issue_fma_i),
        .push_rd_i (trk_io.issue_rd_i),
        .flush_i   (trk_io.flush_i),
        .head_o    (imul_head),
        .live_o    (imul_live)
    );

    // Writeback pairing, flag accrual and misalignment detection
    always_comb begin
        fp_wb_v   = trk_io.fma_v_i & fma_head.v & ~fma_head.kill & ~reset_i;
        // x0 is hardwired; its tag still tracks the pipe but never writes back
        int_wb_v  = trk_io.imul_v_i & imul_head.v & ~imul_head.kill
                  & (imul_head.rd != '0) & ~reset_i;
        new_flags = fp_wb_v ? trk_io.fma_fflags_i : '0;
        fflags_d  = trk_io.fflags_clear_i ? new_flags : (fflags_q | new_flags);
        // Results still draining from before reset have no tags; ignore them while masked
        tag_err   = ((trk_io.fma_v_i ^ fma_head.v) | (trk_io.imul_v_i ^ imul_head.v))
                  & (mask_q == '0);
        err_d     = err_q | tag_err;
        mask_d    = (mask_q != '0) ? (mask_q - mask_width_lp'(1)) : mask_q;
    end

    // Output drive; busy and packets are forced quiet during reset
    always_comb begin
        trk_io.fp_wb_v_o     = fp_wb_v;
        trk_io.fp_wb_rd_o    = fp_wb_v ? fma_head.rd : '0;
        trk_io.fp_wb_data_o  = fp_wb_v ? trk_io.fma_data_i : '0;
        trk_io.int_wb_v_o    = int_wb_v;
        trk_io.int_wb_rd_o   = int_wb_v ? imul_head.rd : '0;
        trk_io.int_wb_data_o = int_wb_v ? trk_io.imul_data_i : '0;
        trk_io.fflags_acc_o  = fflags_q;
        trk_io.err_o         = err_q;
        trk_io.fp_busy_o     = reset_i ? '0 : fma_live;
        trk_io.int_busy_o    = reset_i ? '0 : (imul_live & ~num_regs_gp'(1));
    end

    // Accrued flags, sticky error and post-reset error mask
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fflags_q <= '0;
            err_q    <= 1'b0;
            mask_q   <= mask_init_lp;
        end else begin
            fflags_q <= fflags_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
        end
    end

endmodule

// File: tb/tb_bp_be_fma_wb_tracker.sv
// Self-checking bench for bp_be_fma_wb_tracker: the bench plays the calculator pipe,
// queues expected writebacks at issue and a monitor pops them as the DUT writes back.
module tb_bp_be_fma_wb_tracker;
    import bp_be_fma_wb_tracker_pkg::*;

    localparam int FmaLat  = 5;
    localparam int ImulLat = 4;
    localparam int FpW     = $bits(bp_be_fp_reg_s);

    typedef struct { int due; logic [4:0] rd; logic [FpW-1:0] data; } fp_exp_t;
    typedef struct { int due; logic [4:0] rd; logic [63:0] data; }    int_exp_t;
    typedef struct { int due; logic [FpW-1:0] data; logic [4:0] flags; } fma_arr_t;
    typedef struct { int due; logic [63:0] data; }                    imul_arr_t;

    fp_exp_t   exp_fp[$];
    int_exp_t  exp_int[$];
    fma_arr_t  fma_arr[$];
    imul_arr_t imul_arr[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bp_be_fma_wb_tracker_if trk_if();

    bp_be_fma_wb_tracker #(
        .bp_params_p    (e_bp_default_cfg),
        .fma_latency_p  (FmaLat),
        .imul_latency_p (ImulLat)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .trk_io  (trk_if)
    );

    task automatic clear_inputs();
        trk_if.issue_v_i      = 1'b0;
        trk_if.issue_fma_i    = 1'b0;
        trk_if.issue_rd_i     = '0;
        trk_if.flush_i        = 1'b0;
        trk_if.fma_v_i        = 1'b0;
        trk_if.fma_data_i     = '0;
        trk_if.fma_fflags_i   = '0;
        trk_if.imul_v_i       = 1'b0;
        trk_if.imul_data_i    = '0;
        trk_if.fflags_clear_i = 1'b0;
    endtask

    // Advance one cycle; the bench pipe returns any result due in the new cycle
    task automatic tick();
        fma_arr_t  fa;
        imul_arr_t ia;
        @(posedge clk);
        #1;
        cyc++;
        clear_inputs();
        while (fma_arr.size() > 0 && fma_arr[0].due < cyc) void'(fma_arr.pop_front());
        while (imul_arr.size() > 0 && imul_arr[0].due < cyc) void'(imul_arr.pop_front());
        if (fma_arr.size() > 0 && fma_arr[0].due == cyc) begin
            fa = fma_arr.pop_front();
            trk_if.fma_v_i      = 1'b1;
            trk_if.fma_data_i   = fa.data;
            trk_if.fma_fflags_i = fa.flags;
        end
        if (imul_arr.size() > 0 && imul_arr[0].due == cyc) begin
            ia = imul_arr.pop_front();
            trk_if.imul_v_i    = 1'b1;
            trk_if.imul_data_i = ia.data;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic issue_fma(input logic [4:0] rd, input logic [4:0] flags,
                             input bit expect_wb, input bit has_result);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        trk_if.issue_v_i   = 1'b1;
        trk_if.issue_fma_i = 1'b1;
        trk_if.issue_rd_i  = rd;
        if (has_result) fma_arr.push_back('{cyc + FmaLat - 1, r[FpW-1:0], flags});
        if (expect_wb) exp_fp.push_back('{cyc + FmaLat - 1, rd, r[FpW-1:0]});
    endtask

    task automatic issue_imul(input logic [4:0] rd, input bit expect_wb, input bit has_result);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        trk_if.issue_v_i   = 1'b1;
        trk_if.issue_fma_i = 1'b0;
        trk_if.issue_rd_i  = rd;
        if (has_result) imul_arr.push_back('{cyc + ImulLat - 1, r});
        if (expect_wb) exp_int.push_back('{cyc + ImulLat - 1, rd, r});
    endtask

    // Two reset cycles; returns in the first cycle after reset is released
    task automatic do_reset(input bit drop_pipe);
        n_tests++;
        if (exp_fp.size() != 0 || exp_int.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_wb fp_pending=%0d int_pending=%0d required=0 each",
                     exp_fp.size(), exp_int.size());
        end
        exp_fp.delete();
        exp_int.delete();
        if (drop_pipe) begin
            fma_arr.delete();
            imul_arr.delete();
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_test();
        int c0;
        do_reset(1'b1);
        c0 = cyc;
        goto(c0 + 6);
    endtask

    // Writeback monitor: every valid writeback must match the head of the expected queue
    fp_exp_t  mon_fe;
    int_exp_t mon_ie;
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_fp.size() > 0 && exp_fp[0].due < cyc) begin
                n_tests++;
                n_fail++;
                mon_fe = exp_fp.pop_front();
                $display("FAIL fp_wb_missing rd=%0d due_cycle=%0d seen_by=%0d", mon_fe.rd,
                         mon_fe.due, cyc);
            end
            while (exp_int.size() > 0 && exp_int[0].due < cyc) begin
                n_tests++;
                n_fail++;
                mon_ie = exp_int.pop_front();
                $display("FAIL int_wb_missing rd=%0d due_cycle=%0d seen_by=%0d", mon_ie.rd,
                         mon_ie.due, cyc);
            end
            if (trk_if.fp_wb_v_o === 1'b1) begin
                n_tests++;
                if (exp_fp.size() == 0) begin
                    n_fail++;
                    $display("FAIL fp_wb_unexpected rd=%0d cycle=%0d required=no writeback",
                             trk_if.fp_wb_rd_o, cyc);
                end else begin
                    mon_fe = exp_fp.pop_front();
                    if (mon_fe.due !== cyc || trk_if.fp_wb_rd_o !== mon_fe.rd ||
                        trk_if.fp_wb_data_o !== mon_fe.data) begin
                        n_fail++;
                        $display("FAIL fp_wb got cycle=%0d rd=%0d data=%h required cycle=%0d rd=%0d data=%h",
                                 cyc, trk_if.fp_wb_rd_o, trk_if.fp_wb_data_o, mon_fe.due,
                                 mon_fe.rd, mon_fe.data);
                    end
                end
            end
            if (trk_if.int_wb_v_o === 1'b1) begin
                n_tests++;
                if (exp_int.size() == 0) begin
                    n_fail++;
                    $display("FAIL int_wb_unexpected rd=%0d cycle=%0d required=no writeback",
                             trk_if.int_wb_rd_o, cyc);
                end else begin
                    mon_ie = exp_int.pop_front();
                    if (mon_ie.due !== cyc || trk_if.int_wb_rd_o !== mon_ie.rd ||
                        trk_if.int_wb_data_o !== mon_ie.data) begin
                        n_fail++;
                        $display("FAIL int_wb got cycle=%0d rd=%0d data=%h required cycle=%0d rd=%0d data=%h",
                                 cyc, trk_if.int_wb_rd_o, trk_if.int_wb_data_o, mon_ie.due,
                                 mon_ie.rd, mon_ie.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        int b;
        int p;
        start_test();
        b = cyc;
        issue_fma(5'd2, 5'h1f, 1'b1, 1'b1);
        goto(b + 5);
        trk_if.fma_v_i = 1'b1;               // stray result: head is empty
        goto(b + 6);
        @(negedge clk);
        n_tests++;
        if (trk_if.fflags_acc_o !== 5'h1f) begin
            n_fail++;
            $display("FAIL reset_setup_acc got=%h required=1f", trk_if.fflags_acc_o);
        end
        n_tests++;
        if (trk_if.err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup_err got=%b required=1", trk_if.err_o);
        end
        tick();
        issue_fma(5'd2, 5'h00, 1'b0, 1'b1);
        tick();
        issue_imul(5'd5, 1'b0, 1'b1);
        tick();
        do_reset(1'b0);                       // stale results land in the masked window
        p = cyc;
        @(negedge clk);
        n_tests++;
        if (trk_if.fflags_acc_o !== 5'h00 || trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state acc=%h err=%b required acc=00 err=0",
                     trk_if.fflags_acc_o, trk_if.err_o);
        end
        n_tests++;
        if (trk_if.fp_busy_o !== 32'h0 || trk_if.int_busy_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_busy fp=%h int=%h required 0 each", trk_if.fp_busy_o,
                     trk_if.int_busy_o);
        end
        goto(p + 8);
        @(negedge clk);
        n_tests++;
        if (trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mask_err got=%b required=0", trk_if.err_o);
        end
    endtask

    task automatic test_fma_basic();
        logic [31:0] eb;
        logic [4:0]  ef;
        start_test();
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) issue_fma(5'd7, 5'b00001, 1'b1, 1'b1);
            @(negedge clk);
            eb = (k <= 4) ? 32'h0000_0080 : 32'h0;
            ef = (k == 5) ? 5'd1 : 5'd0;
            n_tests++;
            if (trk_if.fp_busy_o !== eb) begin
                n_fail++;
                $display("FAIL basic_fp_busy k=%0d got=%h required=%h", k, trk_if.fp_busy_o, eb);
            end
            n_tests++;
            if (trk_if.fflags_acc_o !== ef) begin
                n_fail++;
                $display("FAIL basic_acc k=%0d got=%h required=%h", k, trk_if.fflags_acc_o, ef);
            end
            tick();
        end
        n_tests++;
        if (trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err got=%b required=0", trk_if.err_o);
        end
    endtask

    task automatic test_mixed();
        logic [31:0] ei;
        logic [31:0] efp;
        start_test();
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) issue_imul(5'd3, 1'b1, 1'b1);
            if (k == 1) issue_fma(5'd3, 5'b00100, 1'b1, 1'b1);
            @(negedge clk);
            ei  = (k <= 3) ? 32'h8 : 32'h0;
            efp = (k >= 1 && k <= 5) ? 32'h8 : 32'h0;
            n_tests++;
            if (trk_if.int_busy_o !== ei || trk_if.fp_busy_o !== efp) begin
                n_fail++;
                $display("FAIL mixed_busy k=%0d int=%h fp=%h required int=%h fp=%h", k,
                         trk_if.int_busy_o, trk_if.fp_busy_o, ei, efp);
            end
            tick();
        end
        n_tests++;
        if (trk_if.fflags_acc_o !== 5'b00100 || trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_end acc=%h err=%b required acc=04 err=0", trk_if.fflags_acc_o,
                     trk_if.err_o);
        end
    endtask

    task automatic test_flush();
        logic [31:0] efp;
        start_test();
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) issue_fma(5'd9, 5'h1f, 1'b0, 1'b1);
            if (k == 2) trk_if.flush_i = 1'b1;
            if (k == 3) begin
                issue_imul(5'd6, 1'b0, 1'b1);
                trk_if.flush_i = 1'b1;       // flush kills the op issuing alongside it
            end
            @(negedge clk);
            efp = (k <= 1) ? 32'h0000_0200 : 32'h0;
            n_tests++;
            if (trk_if.fp_busy_o !== efp || trk_if.int_busy_o !== 32'h0) begin
                n_fail++;
                $display("FAIL flush_busy k=%0d fp=%h int=%h required fp=%h int=0", k,
                         trk_if.fp_busy_o, trk_if.int_busy_o, efp);
            end
            tick();
        end
        // Flush landing in the same cycle as the result
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) issue_fma(5'd11, 5'h1f, 1'b0, 1'b1);
            if (k == 4) trk_if.flush_i = 1'b1;
            @(negedge clk);
            efp = (k <= 3) ? 32'h0000_0800 : 32'h0;
            n_tests++;
            if (trk_if.fp_busy_o !== efp) begin
                n_fail++;
                $display("FAIL flush_arrive_busy k=%0d got=%h required=%h", k,
                         trk_if.fp_busy_o, efp);
            end
            tick();
        end
        n_tests++;
        if (trk_if.fflags_acc_o !== 5'h00 || trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end acc=%h err=%b required acc=00 err=0", trk_if.fflags_acc_o,
                     trk_if.err_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eb;
        logic [4:0]  ef;
        start_test();
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) issue_fma(5'd4, 5'b00010, 1'b1, 1'b1);
            if (k == 1) issue_fma(5'd4, 5'b01000, 1'b1, 1'b1);
            @(negedge clk);
            eb = (k <= 5) ? 32'h10 : 32'h0;
            ef = (k == 5) ? 5'b00010 : ((k == 6) ? 5'b01010 : 5'b00000);
            n_tests++;
            if (trk_if.fp_busy_o !== eb || trk_if.fflags_acc_o !== ef) begin
                n_fail++;
                $display("FAIL b2b k=%0d busy=%h acc=%h required busy=%h acc=%h", k,
                         trk_if.fp_busy_o, trk_if.fflags_acc_o, eb, ef);
            end
            tick();
        end
    endtask

    task automatic test_fflags_clear();
        logic [4:0] ef;
        start_test();
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) issue_fma(5'd1, 5'b00011, 1'b1, 1'b1);
            if (k == 2) issue_fma(5'd2, 5'b10000, 1'b1, 1'b1);
            if (k == 3) issue_fma(5'd3, 5'b00100, 1'b1, 1'b1);
            if (k == 6 || k == 9) trk_if.fflags_clear_i = 1'b1;
            @(negedge clk);
            if (k <= 4)      ef = 5'b00000;
            else if (k <= 6) ef = 5'b00011;
            else if (k == 7) ef = 5'b10000;
            else if (k <= 9) ef = 5'b10100;
            else             ef = 5'b00000;
            n_tests++;
            if (trk_if.fflags_acc_o !== ef) begin
                n_fail++;
                $display("FAIL fflags k=%0d got=%h required=%h", k, trk_if.fflags_acc_o, ef);
            end
            tick();
        end
    endtask

    task automatic test_imul_rd0();
        logic [31:0] ei;
        start_test();
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) issue_imul(5'd0, 1'b0, 1'b1);
            if (k == 1) issue_imul(5'd13, 1'b1, 1'b1);
            @(negedge clk);
            ei = (k >= 1 && k <= 4) ? 32'h0000_2000 : 32'h0;
            n_tests++;
            if (trk_if.int_busy_o !== ei) begin
                n_fail++;
                $display("FAIL rd0_busy k=%0d got=%h required=%h", k, trk_if.int_busy_o, ei);
            end
            tick();
        end
        n_tests++;
        if (trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd0_err got=%b required=0", trk_if.err_o);
        end
    endtask

    task automatic test_err();
        int b;
        start_test();
        b = cyc;
        trk_if.fma_v_i = 1'b1;               // result with no tag in flight
        @(negedge clk);
        n_tests++;
        if (trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early got=%b required=0", trk_if.err_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (trk_if.err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set got=%b required=1", trk_if.err_o);
        end
        goto(b + 5);
        @(negedge clk);
        n_tests++;
        if (trk_if.err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky got=%b required=1", trk_if.err_o);
        end
        // Tag arrives at the head but the pipe never returns the result
        start_test();
        b = cyc;
        issue_imul(5'd8, 1'b0, 1'b0);
        goto(b + 3);
        @(negedge clk);
        n_tests++;
        if (trk_if.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_missing_early got=%b required=0", trk_if.err_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (trk_if.err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_missing got=%b required=1", trk_if.err_o);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fma_basic();
        test_mixed();
        test_flush();
        test_back_to_back();
        test_fflags_clear();
        test_imul_rd0();
        test_err();
        do_reset(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "bench did not finish in time");
    end

endmodule
